// File: rtl/rom_cache_pkg.sv
// Shared types and defaults for the ROM fetch cache and its storage array.
package rom_cache_pkg;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 29;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESPOND
  } fetch_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rom_cache_array.sv
// Tag and data storage for the fetch cache: one asynchronous read port, one synchronous write port.
module rom_cache_array
  import rom_cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 12,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [IDX_W-1:0]  wrIdx_i,
  input  logic [TAG_W-1:0]  wrTag_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [IDX_W-1:0]  rdIdx_i,
  output logic [TAG_W-1:0]  rdTag_o,
  output logic [DATA_W-1:0] rdData_o
);

  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [DATA_W-1:0] dataMem [LINES];

  // Contents are qualified by valid bits held in the parent, so no reset here.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      tagMem[wrIdx_i]  <= wrTag_i;
      dataMem[wrIdx_i] <= wrData_i;
    end
  end

  assign rdTag_o  = tagMem[rdIdx_i];
  assign rdData_o = dataMem[rdIdx_i];

endmodule

// File: rtl/rom_fetch_cache.sv
// Direct-mapped instruction fetch cache between the CPU fetch port and a slow flash controller.
// Valid bits live here so an invalidate can clear every line on a single edge.
module rom_fetch_cache
  import rom_cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_start,
  input  logic [DATA_W-1:0] flash_data,
  input  logic              flash_valid,
  input  logic              flash_busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  if (LINES < 4 || LINES > 64 || (LINES & (LINES - 1)) != 0) begin : gLinesCheck
    $error("rom_fetch_cache: LINES must be a power of 2 in 4..64");
  end

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] cpuData_q, cpuData_d;
  logic              cpuValid_q, cpuValid_d;
  logic [CNT_W-1:0]  hitCnt_q, hitCnt_d;
  logic [CNT_W-1:0]  missCnt_q, missCnt_d;

  logic [IDX_W-1:0]  lineIdx;
  logic [TAG_W-1:0]  lineTag, rdTag;
  logic [DATA_W-1:0] rdData;
  logic              lineHit, accept, lookupHit, lookupMiss, startRead, fill;

  assign lineIdx = addr_q[IDX_W-1:0];
  assign lineTag = addr_q[ADDR_W-1:IDX_W];

  rom_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) uArray (
    .clk     (clk),
    .wrEn_i  (fill),
    .wrIdx_i (lineIdx),
    .wrTag_i (lineTag),
    .wrData_i(flash_data),
    .rdIdx_i (lineIdx),
    .rdTag_o (rdTag),
    .rdData_o(rdData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept)      state_d = LOOKUP;
      LOOKUP:    state_d = lookupHit ? IDLE : MISS_REQ;
      MISS_REQ:  if (startRead)   state_d = MISS_WAIT;
      MISS_WAIT: if (fill)        state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A request is not re-accepted while its own response is still on the bus.
  always_comb begin
    accept     = 1'b0;
    lookupHit  = 1'b0;
    lookupMiss = 1'b0;
    startRead  = 1'b0;
    fill       = 1'b0;
    lineHit    = valid_q[lineIdx] && (rdTag == lineTag);
    unique case (state_q)
      IDLE:      accept = cpu_req && !cpuValid_q;
      LOOKUP:    begin
        lookupHit  = lineHit;
        lookupMiss = !lineHit;
      end
      MISS_REQ:  startRead = !flash_busy;
      MISS_WAIT: fill = flash_valid;
      default:   ;
    endcase
  end

  // Invalidate has the last word, so a fill landing on the same edge stays invalid.
  always_comb begin
    addr_d     = accept ? cpu_addr : addr_q;
    cpuValid_d = lookupHit || fill;
    cpuData_d  = cpuData_q;
    if (lookupHit)  cpuData_d = rdData;
    else if (fill)  cpuData_d = flash_data;
    valid_d = valid_q;
    if (fill)       valid_d[lineIdx] = 1'b1;
    if (invalidate) valid_d = '0;
    hitCnt_d  = lookupHit  ? satInc(hitCnt_q)  : hitCnt_q;
    missCnt_d = lookupMiss ? satInc(missCnt_q) : missCnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      valid_q    <= '0;
      cpuData_q  <= '0;
      cpuValid_q <= 1'b0;
      hitCnt_q   <= '0;
      missCnt_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      cpuData_q  <= cpuData_d;
      cpuValid_q <= cpuValid_d;
      hitCnt_q   <= hitCnt_d;
      missCnt_q  <= missCnt_d;
    end
  end

  assign cpu_data    = cpuData_q;
  assign cpu_valid   = cpuValid_q;
  assign flash_addr  = addr_q;
  assign flash_start = startRead;
  assign hit_count   = hitCnt_q;
  assign miss_count  = missCnt_q;

endmodule

// File: doc/rom_fetch_cache.md
ROM_FETCH_CACHE -- requirements
Module: rom_fetch_cache

Interface
REQ-001 Parameter LINES, default 16, means the number of direct-mapped single-word lines; it SHALL be a power of 2 in the range 4..64.
REQ-002 Parameter ADDR_W, default 16, means the instruction address width.
REQ-003 Parameter DATA_W, default 29, means the instruction word width.
REQ-004 clk  input  1  is the single clock; all state SHALL be on its rising edge.
REQ-005 rst  input  1  is the reset, asynchronous and active-high.
REQ-006 cpu_req  input  1  requests a fetch of cpu_addr; the requester holds it high, with cpu_addr stable, until cpu_valid.
REQ-007 cpu_addr  input  ADDR_W  is the instruction word address.
REQ-008 cpu_data  output  DATA_W  is the fetched instruction.
REQ-009 cpu_valid  output  1  is a one-cycle pulse qualifying cpu_data.
REQ-010 invalidate  input  1  is a one-cycle request to clear all lines.
REQ-011 flash_addr  output  ADDR_W  is the miss address sent to the flash controller.
REQ-012 flash_start  output  1  is a one-cycle read-start pulse to the flash controller.
REQ-013 flash_data  input  DATA_W  is the flash read word.
REQ-014 flash_valid  input  1  is a one-cycle pulse qualifying flash_data.
REQ-015 flash_busy  input  1  indicates that the flash controller is not ready to accept a start.
REQ-016 hit_count, miss_count  output  16  are saturating statistics counters.

Function
REQ-017 The index SHALL be cpu_addr[log2(LINES)-1:0], and the tag SHALL be the remaining upper bits.
REQ-018 The FSM SHALL have states IDLE, LOOKUP, MISS_REQ, MISS_WAIT and RESPOND.
REQ-019 In IDLE with cpu_req=1, the FSM SHALL latch the address and go to LOOKUP next cycle.
REQ-020 In LOOKUP on a hit (valid & tag match), the block SHALL drive cpu_data from the line and pulse cpu_valid in that cycle, giving hit latency = 2 cycles from cpu_req, and SHALL return to IDLE.
REQ-021 In LOOKUP on a miss, the FSM SHALL go to MISS_REQ.
REQ-022 In MISS_REQ, the block SHALL wait while flash_busy=1; otherwise it SHALL pulse flash_start for exactly one cycle with flash_addr = the latched address and go to MISS_WAIT.
REQ-023 In MISS_WAIT on flash_valid, the block SHALL write data/tag/valid into the line, register flash_data and go to RESPOND.
REQ-024 In RESPOND, the block SHALL pulse cpu_valid with the registered word and return to IDLE; miss latency = flash latency + 3 cycles.
REQ-025 flash_addr SHALL remain stable from flash_start until flash_valid.
REQ-026 flash_valid outside MISS_WAIT SHALL be ignored.
REQ-027 The block SHALL allow at most one outstanding flash read.
REQ-028 Changes of cpu_addr while not in IDLE SHALL be ignored, because the address is latched.
REQ-029 invalidate SHALL clear every valid bit on the next edge.
REQ-030 If invalidate coincides with the flash_valid fill, the word SHALL still be returned, but the line SHALL remain invalid.
REQ-031 If invalidate occurs in LOOKUP, that lookup SHALL use the pre-invalidate valid bits.
REQ-032 hit_count SHALL increment once per hit and miss_count once per miss, each saturating at 16'hFFFF with no wrap.
REQ-033 cpu_valid and flash_start SHALL never be asserted in the same cycle.

Reset
REQ-034 On rst=1, the block SHALL immediately return to IDLE and clear all valid bits, cpu_valid, flash_start, cpu_data, flash_addr, hit_count and miss_count to 0.
REQ-035 A reset during MISS_WAIT SHALL abandon the read, and a later stale flash_valid SHALL be ignored.
REQ-036 The data and tag arrays SHALL need no reset; only the valid bits SHALL be reset.

Structure
REQ-037 Shared package rom_cache_pkg SHALL hold the FSM state enum and the default ADDR_W/DATA_W constants.
REQ-038 The tag/data storage SHALL be one sub-module, rom_cache_array, with 1 read port, 1 write port and a synchronous write; the valid bits SHALL stay in the top level for single-cycle invalidate.
REQ-039 The RTL SHALL use no other sub-modules.

Verification
REQ-040 Cold miss: with the flash model returning 29'h0ABCDEF after 5 cycles, reset, then cpu_req with addr 16'h0012 -> one flash_start with flash_addr=16'h0012, then cpu_valid with cpu_data=29'h0ABCDEF 8 cycles after the request, and miss_count=1.
REQ-041 Hit: a repeat request to 16'h0012 -> cpu_valid 2 cycles after the request with no flash_start, and hit_count=1.
REQ-042 Conflict: request 16'h0002 after 16'h0012 (LINES=16) -> miss that refills the line; a subsequent request to 16'h0012 misses again, and miss_count=3.
REQ-043 Busy/invalidate: with flash_busy held 4 cycles, flash_start SHALL be delayed 4 cycles; invalidate asserted together with flash_valid -> data returned, and the next same-address request misses.
REQ-044 Reset mid-miss: assert rst in MISS_WAIT, then inject flash_valid -> no cpu_valid, the state SHALL be IDLE, and both counters SHALL be 0.
REQ-045 Saturation: force 65537 hits -> hit_count SHALL remain at 16'hFFFF.
